// File: rtl/pc_fetch_sequencer_if.sv
// Fetch sequencer bus: PC input, I-cache read port, IQ push port, redirect
// requests and program_counter load strobes, grouped for the sequencer (master).
interface pc_fetch_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] pc_i;
    logic             icache_read_o;
    logic [WIDTH-1:0] icache_addr_o;
    logic             icache_resp_i;
    logic [31:0]      icache_rdata_i;
    logic             iq_full_i;
    logic             fetch_valid_o;
    logic [31:0]      fetch_instr_o;
    logic [WIDTH-1:0] fetch_pc_o;
    logic             flush_i;
    logic [WIDTH-1:0] flush_pc_i;
    logic             jalr_valid_i;
    logic [WIDTH-1:0] jalr_target_i;
    logic             jal_valid_i;
    logic [WIDTH-1:0] jal_offset_i;
    logic             load_plus_four_o;
    logic             load_offset_o;
    logic [WIDTH-1:0] offset_o;
    logic             load_branch_o;
    logic [WIDTH-1:0] branch_pc_o;
    logic             load_alu_mod2_o;
    logic [WIDTH-1:0] jalr_alu_out_o;

    modport master (
        input  pc_i, icache_resp_i, icache_rdata_i, iq_full_i,
               flush_i, flush_pc_i, jalr_valid_i, jalr_target_i,
               jal_valid_i, jal_offset_i,
        output icache_read_o, icache_addr_o, fetch_valid_o, fetch_instr_o,
               fetch_pc_o, load_plus_four_o, load_offset_o, offset_o,
               load_branch_o, branch_pc_o, load_alu_mod2_o, jalr_alu_out_o
    );

    modport slave (
        output pc_i, icache_resp_i, icache_rdata_i, iq_full_i,
               flush_i, flush_pc_i, jalr_valid_i, jalr_target_i,
               jal_valid_i, jal_offset_i,
        input  icache_read_o, icache_addr_o, fetch_valid_o, fetch_instr_o,
               fetch_pc_o, load_plus_four_o, load_offset_o, offset_o,
               load_branch_o, branch_pc_o, load_alu_mod2_o, jalr_alu_out_o
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Sequences I-cache fetch into the IQ and arbitrates PC redirects
// (flush > jalr > jal), driving at most one program_counter load strobe.
module pc_fetch_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input logic                 clk,
    input logic                 rst,
    pc_fetch_sequencer_if.master bus
);
    typedef enum logic {ST_FETCH, ST_HOLD} state_e;
    // Encoding order doubles as priority order for the replace rule.
    typedef enum logic [1:0] {REQ_NONE = 2'd0, REQ_JAL = 2'd1, REQ_JALR = 2'd2, REQ_FLUSH = 2'd3} req_e;

    state_e           state_q, state_d;
    req_e             pend_type_q, pend_type_d;
    logic [WIDTH-1:0] pend_val_q, pend_val_d;
    logic [31:0]      hold_instr_q, hold_instr_d;
    logic [WIDTH-1:0] hold_pc_q, hold_pc_d;

    req_e             new_type, eff_type;
    logic [WIDTH-1:0] new_val, eff_val;
    logic             fire;

    always_comb begin
        new_type = REQ_NONE;
        new_val  = '0;
        if (bus.flush_i) begin
            new_type = REQ_FLUSH;
            new_val  = bus.flush_pc_i;
        end else if (bus.jalr_valid_i) begin
            new_type = REQ_JALR;
            new_val  = bus.jalr_target_i;
        end else if (bus.jal_valid_i) begin
            new_type = REQ_JAL;
            new_val  = bus.jal_offset_i;
        end
        if (new_type != REQ_NONE && new_type >= pend_type_q) begin
            eff_type = new_type;
            eff_val  = new_val;
        end else begin
            eff_type = pend_type_q;
            eff_val  = pend_val_q;
        end
    end

    always_comb begin
        state_d          = state_q;
        pend_type_d      = pend_type_q;
        pend_val_d       = pend_val_q;
        hold_instr_d     = hold_instr_q;
        hold_pc_d        = hold_pc_q;
        fire             = 1'b0;
        bus.icache_read_o    = 1'b0;
        bus.icache_addr_o    = '0;
        bus.fetch_valid_o    = 1'b0;
        bus.fetch_instr_o    = '0;
        bus.fetch_pc_o       = '0;
        bus.load_plus_four_o = 1'b0;
        bus.load_offset_o    = 1'b0;
        bus.offset_o         = '0;
        bus.load_branch_o    = 1'b0;
        bus.branch_pc_o      = '0;
        bus.load_alu_mod2_o  = 1'b0;
        bus.jalr_alu_out_o   = '0;

        if (!rst) begin
            bus.icache_addr_o = bus.pc_i;
            case (state_q)
                ST_FETCH: begin
                    bus.icache_read_o = 1'b1;
                    if (!bus.icache_resp_i) begin
                        // PC is frozen while the read is outstanding, so a buffered JAL offset stays valid.
                        pend_type_d = eff_type;
                        pend_val_d  = eff_val;
                    end else begin
                        pend_type_d = REQ_NONE;
                        pend_val_d  = '0;
                        if (eff_type != REQ_NONE) begin
                            fire = 1'b1;
                        end else if (!bus.iq_full_i) begin
                            bus.fetch_valid_o    = 1'b1;
                            bus.fetch_instr_o    = bus.icache_rdata_i;
                            bus.fetch_pc_o       = bus.pc_i;
                            bus.load_plus_four_o = 1'b1;
                        end else begin
                            hold_instr_d = bus.icache_rdata_i;
                            hold_pc_d    = bus.pc_i;
                            state_d      = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    pend_type_d = REQ_NONE;
                    pend_val_d  = '0;
                    if (eff_type != REQ_NONE) begin
                        fire    = 1'b1;
                        state_d = ST_FETCH;
                    end else if (!bus.iq_full_i) begin
                        bus.fetch_valid_o    = 1'b1;
                        bus.fetch_instr_o    = hold_instr_q;
                        bus.fetch_pc_o       = hold_pc_q;
                        bus.load_plus_four_o = 1'b1;
                        state_d              = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end

        if (fire) begin
            case (eff_type)
                REQ_FLUSH: begin
                    bus.load_branch_o = 1'b1;
                    bus.branch_pc_o   = eff_val;
                end
                REQ_JALR: begin
                    bus.load_alu_mod2_o = 1'b1;
                    bus.jalr_alu_out_o  = eff_val;
                end
                REQ_JAL: begin
                    bus.load_offset_o = 1'b1;
                    bus.offset_o      = eff_val;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            pend_type_q  <= REQ_NONE;
            pend_val_q   <= '0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pend_type_q  <= pend_type_d;
            pend_val_q   <= pend_val_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end
endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Controller that owns the program_counter load strobes and sequences instruction fetch from the I-cache into the instruction queue (IQ).
- Arbitrates PC redirect requests from three sources: ROB mispredict/flush, JALR resolution, and JAL decode. Drives at most one PC load strobe per cycle.
- Buffers one pending redirect while an I-cache read is outstanding. Holds one fetched instruction when the IQ applies backpressure.

Parameters:
WIDTH, 32, PC/data width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
pc_i  in  WIDTH  current program_counter output
icache_read_o  out  1  I-cache read request
icache_addr_o  out  WIDTH  read address (= pc_i)
icache_resp_i  in  1  read complete; icache_rdata_i valid this cycle
icache_rdata_i  in  32  fetched instruction
iq_full_i  in  1  IQ cannot accept this cycle
fetch_valid_o  out  1  instruction/PC pushed to IQ this cycle
fetch_instr_o  out  32  instruction to IQ
fetch_pc_o  out  WIDTH  PC of that instruction
flush_i  in  1  ROB mispredict redirect
flush_pc_i  in  WIDTH  absolute flush target
jalr_valid_i  in  1  JALR resolved
jalr_target_i  in  WIDTH  raw ALU sum (unmasked)
jal_valid_i  in  1  JAL decoded
jal_offset_i  in  WIDTH  offset relative to pc_i in the request cycle
load_plus_four_o  out  1  PC += 4
load_offset_o  out  1  PC += offset_o
offset_o  out  WIDTH  offset for load_offset_o
load_branch_o  out  1  PC = branch_pc_o
branch_pc_o  out  WIDTH  absolute target
load_alu_mod2_o  out  1  PC = jalr_alu_out_o & ~1
jalr_alu_out_o  out  WIDTH  JALR target

Behaviour:
- States: FETCH (read outstanding) and HOLD (instruction latched, waiting for IQ).
- Reset: state=FETCH, pending redirect cleared, hold register cleared. All outputs 0 while rst=1.
- icache_read_o = (state==FETCH) && !rst. icache_addr_o = pc_i.
- Redirect priority: flush > jalr > jal. The effective request in a cycle is the highest-priority of the new inputs and the pending register.
- A flush always overwrites the pending register. A new request replaces a pending one only if its priority is higher or equal; otherwise it is dropped.
- Pending type encoding: NONE / JAL / JALR / FLUSH, plus one WIDTH payload.
- FETCH, no icache_resp_i:
  - any new request is captured into pending; no load strobe; stay in FETCH.
  - PC cannot move while a read is outstanding, so the JAL offset stays valid.
- FETCH, icache_resp_i with an effective redirect:
  - response discarded (fetch_valid_o=0);
  - the matching load strobe fires this cycle with its payload;
  - pending cleared; stay in FETCH.
  - Strobe mapping: FLUSH -> load_branch_o; JALR -> load_alu_mod2_o; JAL -> load_offset_o.
- FETCH, icache_resp_i, no redirect, !iq_full_i:
  - fetch_valid_o=1, fetch_instr_o=icache_rdata_i, fetch_pc_o=pc_i;
  - load_plus_four_o=1; stay in FETCH.
- FETCH, icache_resp_i, no redirect, iq_full_i:
  - latch instruction and pc_i into the hold register; no strobe; go to HOLD.
- HOLD with an effective redirect:
  - held instruction dropped; strobe fires the same cycle; go to FETCH.
- HOLD, no redirect, !iq_full_i:
  - push held instruction (fetch_valid_o=1); load_plus_four_o=1; go to FETCH.
- HOLD, no redirect, iq_full_i: stay in HOLD. Outputs are don't-care apart from fetch_valid_o=0.
- Invariant: at most one load_* high per cycle. Loads only occur in a response cycle or in HOLD.
- All datapath outputs are combinational from state, pending and inputs. Fetch-to-IQ latency is the same cycle as icache_resp_i.
- rst mid-read: state returns to FETCH and pending is cleared. A stale response arriving in the first post-reset cycle is accepted normally (I-cache is also reset).

Test Plan:
- Reset, then pc_i=0x60 and resp on cycle 3 with rdata=0x00000013 -> icache_read_o=1 with addr 0x60; on cycle 3 fetch_valid_o=1, fetch_pc_o=0x60, load_plus_four_o=1.
- jal_valid_i (offset 0x20) two cycles before resp -> no strobe until resp; at resp fetch_valid_o=0, load_offset_o=1, offset_o=0x20.
- jal pending, then jalr_valid_i (target 0x1235), then flush_i (pc 0x400) before resp -> at resp only load_branch_o=1 with branch_pc_o=0x400.
- jalr pending (0x1235), then jal arrives -> jal dropped; at resp load_alu_mod2_o=1 with jalr_alu_out_o=0x1235.
- resp with iq_full_i=1 for 3 cycles, then 0 -> HOLD for 3 cycles with no strobes; on the 4th cycle fetch_valid_o=1 with the original pc and load_plus_four_o=1.
- In HOLD, flush_i (0x80) -> same cycle load_branch_o=1 and fetch_valid_o=0; next cycle icache_read_o=1.
